// File: rtl/twiddle_stream_gen_pkg.sv
// Shared constants, FSM encoding and sign helpers for the twiddle stream generator.
// Minifloat formats: FP8 E4M3 (sign bit 7) and FP4 E2M1 (sign bit 3).
package twiddle_stream_gen_pkg;

    localparam logic [7:0] FP8_ONE      = 8'h38;
    localparam logic [7:0] FP8_ZERO     = 8'h00;
    localparam logic [3:0] FP4_ONE      = 4'h2;
    localparam logic [3:0] FP4_ZERO     = 4'h0;
    localparam int         FP8_SIGN_BIT = 7;
    localparam int         FP4_SIGN_BIT = 3;
    localparam int         ROM_W        = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Zero keeps a positive sign so the stream never carries -0.
    function automatic logic [7:0] neg_fp8(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[FP8_SIGN_BIT-1:0] != '0) r[FP8_SIGN_BIT] = ~v[FP8_SIGN_BIT];
        return r;
    endfunction

    function automatic logic [3:0] neg_fp4(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (v[FP4_SIGN_BIT-1:0] != '0) r[FP4_SIGN_BIT] = ~v[FP4_SIGN_BIT];
        return r;
    endfunction

endpackage

// File: rtl/twiddle_qtr_rom.sv
// Quarter-wave cosine table, entries {fp8[7:0], fp4[3:0]} of cos(2*pi*i/MAX_N), i = 0..MAX_N/4.
// Image generated offline at 64-point resolution; smaller MAX_N read it with a stride.
module twiddle_qtr_rom
    import twiddle_stream_gen_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int AW    = $clog2(MAX_N) - 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic [ROM_W-1:0] data_a,
    output logic [ROM_W-1:0] data_b
);

    localparam int STRIDE = (MAX_N >= 64) ? 1 : 64 / MAX_N;

    function automatic logic [ROM_W-1:0] qtr_entry(input logic [AW-1:0] addr);
        int unsigned idx;
        idx = int'(addr) * STRIDE;
        case (idx)
            0:       qtr_entry = {FP8_ONE, FP4_ONE};
            1:       qtr_entry = 12'h382;
            2:       qtr_entry = 12'h382;
            3:       qtr_entry = 12'h372;
            4:       qtr_entry = 12'h372;
            5:       qtr_entry = 12'h362;
            6:       qtr_entry = 12'h352;
            7:       qtr_entry = 12'h342;
            8:       qtr_entry = 12'h331;
            9:       qtr_entry = 12'h321;
            10:      qtr_entry = 12'h311;
            11:      qtr_entry = 12'h2F1;
            12:      qtr_entry = 12'h2C1;
            13:      qtr_entry = 12'h291;
            14:      qtr_entry = 12'h240;
            15:      qtr_entry = 12'h1D0;
            default: qtr_entry = {FP8_ZERO, FP4_ZERO};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= qtr_entry(addr_a);
            data_b <= qtr_entry(addr_b);
        end
    end

endmodule

// File: rtl/twiddle_stream_gen.sv
// Streams one radix-2 DIT stage's twiddles W_N^k through a 3-stage pipeline
// (index/angle, ROM read, sign/format) with a valid/ready output handshake.
module twiddle_stream_gen
    import twiddle_stream_gen_pkg::*;
#(
    parameter int MAX_N     = 64,
    parameter int LOG2_MAXN = $clog2(MAX_N)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(LOG2_MAXN+1)-1:0] n_log2,
    input  logic [$clog2(LOG2_MAXN)-1:0]   stage,
    input  logic                           precision,
    input  logic                           inverse,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    twiddle_out,
    output logic [LOG2_MAXN-1:0]           out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err,
    output state_t                         dbg_state
);

    localparam int NW = $clog2(LOG2_MAXN + 1);
    localparam int SW = $clog2(LOG2_MAXN);
    localparam int AW = LOG2_MAXN - 1;
    localparam logic [AW-1:0] Q_A = AW'(MAX_N / 4);

    // Handshake: a twiddle transfers on a clk edge where out_valid && out_ready;
    // while out_valid && !out_ready every stage and the j counter hold.
    logic advance;
    assign advance = !(out_valid && !out_ready);

    state_t        state, state_nxt;
    logic [NW-1:0] cfg_n;
    logic [SW-1:0] cfg_s;
    logic          cfg_prec, cfg_inv;
    logic [AW-1:0] j_cnt;

    logic          cfg_bad, start_ok, issue, j_is_last;
    logic [NW-1:0] k_shift, m_shift;
    logic [AW-1:0] s_mask, j_last_val, k_nxt, m_nxt;

    assign cfg_bad  = (n_log2 == '0) || (n_log2 > NW'(LOG2_MAXN)) || (NW'(stage) >= n_log2);
    assign start_ok = start && !cfg_bad;
    assign issue    = (state == RUN) && advance;

    assign k_shift    = cfg_n - NW'(1) - NW'(cfg_s);
    assign m_shift    = NW'(LOG2_MAXN) - cfg_n;
    assign s_mask     = (AW'(1) << cfg_s) - AW'(1);
    assign j_last_val = (AW'(1) << (cfg_n - NW'(1))) - AW'(1);
    assign j_is_last  = (j_cnt == j_last_val);
    assign k_nxt      = (j_cnt & s_mask) << k_shift;
    assign m_nxt      = k_nxt << m_shift;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (issue && j_is_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_valid && !s2_valid && !out_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cfg_n    <= '0;
            cfg_s    <= '0;
            cfg_prec <= 1'b0;
            cfg_inv  <= 1'b0;
            j_cnt    <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= (state == IDLE) && start && cfg_bad;
            if (state == IDLE && start_ok) begin
                cfg_n    <= n_log2;
                cfg_s    <= stage;
                cfg_prec <= precision;
                cfg_inv  <= inverse;
                j_cnt    <= '0;
            end else if (issue) begin
                j_cnt <= j_cnt + AW'(1);
            end
        end
    end

    logic          s1_valid, s1_last;
    logic [AW-1:0] s1_k, s1_m;
    logic          s2_valid, s2_last, s2_neg_re;
    logic [AW-1:0] s2_k;
    logic [AW-1:0] addr_re, addr_im;
    logic [ROM_W-1:0] rom_re, rom_im;

    // Fold the half-circle angle onto the quarter table: re from one port, im from the other.
    always_comb begin
        if (s1_m < Q_A) begin
            addr_re = s1_m;
            addr_im = Q_A - s1_m;
        end else begin
            addr_re = Q_A - (s1_m - Q_A);
            addr_im = s1_m - Q_A;
        end
    end

    twiddle_qtr_rom #(
        .MAX_N (MAX_N),
        .AW    (AW)
    ) u_rom (
        .clk    (clk),
        .en     (advance),
        .addr_a (addr_re),
        .addr_b (addr_im),
        .data_a (rom_re),
        .data_b (rom_im)
    );

    logic [7:0]  re8, im8;
    logic [3:0]  re4, im4;
    logic [15:0] tw_fmt;

    always_comb begin
        re8 = rom_re[11:4];
        re4 = rom_re[3:0];
        im8 = neg_fp8(rom_im[11:4]);
        im4 = neg_fp4(rom_im[3:0]);
        if (s2_neg_re) begin
            re8 = neg_fp8(re8);
            re4 = neg_fp4(re4);
        end
        if (cfg_inv) begin
            im8 = neg_fp8(im8);
            im4 = neg_fp4(im4);
        end
        tw_fmt = cfg_prec ? {re8, im8} : {FP8_ZERO, re4, im4};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_k        <= '0;
            s1_m        <= '0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            s2_neg_re   <= 1'b0;
            s2_k        <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_index   <= '0;
            twiddle_out <= '0;
        end else if (advance) begin
            s1_valid    <= (state == RUN);
            s1_last     <= (state == RUN) && j_is_last;
            s1_k        <= k_nxt;
            s1_m        <= m_nxt;
            s2_valid    <= s1_valid;
            s2_last     <= s1_last;
            s2_neg_re   <= (s1_m >= Q_A);
            s2_k        <= s1_k;
            out_valid   <= s2_valid;
            out_last    <= s2_valid && s2_last;
            out_index   <= s2_valid ? {1'b0, s2_k} : '0;
            twiddle_out <= s2_valid ? tw_fmt : '0;
        end
    end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Scoreboard bench for twiddle_stream_gen: a trig-based reference model fills the
// expected queue at each start and a negedge monitor pops on every handshake.
module tb_twiddle_stream_gen;
    import twiddle_stream_gen_pkg::*;

    localparam int  MAX_N = 32;
    localparam int  L     = 5;
    localparam int  NW    = $clog2(L + 1);
    localparam int  SW    = $clog2(L);
    localparam int  W     = 16 + L + 1;
    localparam real PI    = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n_log2 = '0;
    logic [SW-1:0] stage = '0;
    logic          precision = 1'b0;
    logic          inverse = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid, out_last, busy, done, cfg_err;
    logic [15:0]   twiddle_out;
    logic [L-1:0]  out_index;
    state_t        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  cap_tw[32];
    int hs_cnt = 0, base_hs = 0, stall_seen = 0, ready_mode = 0, stall_cnt = 0;
    bit mon_off = 1'b0, done_due = 1'b0, held_v = 1'b0;
    logic [W-1:0] held;

    twiddle_stream_gen #(.MAX_N(MAX_N), .LOG2_MAXN(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_log2(n_log2), .stage(stage),
        .precision(precision), .inverse(inverse), .out_valid(out_valid),
        .out_ready(out_ready), .twiddle_out(twiddle_out), .out_index(out_index),
        .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) repeat (e) p = p * 2.0;
        else repeat (-e) p = p / 2.0;
        return p;
    endfunction

    function automatic real val8(input int c);
        int e, m;
        e = c / 8;
        m = c % 8;
        if (e == 0) return (m / 8.0) * pow2(-6);
        return (1.0 + m / 8.0) * pow2(e - 7);
    endfunction

    function automatic real val4(input int c);
        int e, m;
        e = c / 2;
        m = c % 2;
        if (e == 0) return m * 0.5;
        return (1.0 + m / 2.0) * pow2(e - 1);
    endfunction

    // Round-to-nearest-even over every finite magnitude code.
    function automatic int nearest(input real a, input bit fp8);
        int best, top;
        real bd, d;
        best = 0;
        bd   = 1.0e9;
        top  = fp8 ? 126 : 7;
        for (int c = 0; c <= top; c++) begin
            d = (fp8 ? val8(c) : val4(c)) - a;
            if (d < 0.0) d = -d;
            if (d < bd || (d == bd && (c % 2) == 0)) begin
                bd   = d;
                best = c;
            end
        end
        return best;
    endfunction

    function automatic logic [7:0] enc8(input real x);
        int c;
        c = nearest((x < 0.0) ? -x : x, 1'b1);
        if (c == 0) return 8'h00;
        return {(x < 0.0), 7'(c)};
    endfunction

    function automatic logic [3:0] enc4(input real x);
        int c;
        c = nearest((x < 0.0) ? -x : x, 1'b0);
        if (c == 0) return 4'h0;
        return {(x < 0.0), 3'(c)};
    endfunction

    task automatic push_model(input int n, input int s, input bit p, input bit iv);
        int nn;
        nn = 1 << n;
        for (int j = 0; j < nn / 2; j++) begin
            int k;
            real th, re, im;
            logic [15:0] tw;
            k  = (j % (1 << s)) * (1 << (n - 1 - s));
            th = 2.0 * PI * k / nn;
            re = $cos(th);
            im = -$sin(th);
            if (iv) im = -im;
            tw = p ? {enc8(re), enc8(im)} : {8'h00, enc4(re), enc4(im)};
            exp_q.push_back({tw, L'(k), (j == nn / 2 - 1)});
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_cnt > 0) begin
                        out_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got, expv;
        if (!rst_n || mon_off) begin
            held_v   = 1'b0;
            done_due = 1'b0;
        end else begin
            got = {twiddle_out, out_index, out_last};
            if (done_due) begin
                check("done_after_last", 32'(done), 32'd1);
                done_due = 1'b0;
            end
            if (held_v) check("stall_hold", 32'({out_valid, got}), 32'({1'b1, held}));
            held_v = 1'b0;
            if (out_valid && !out_ready) begin
                held_v = 1'b1;
                held   = got;
                stall_seen++;
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                cap_tw[out_index] = twiddle_out;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h, expected no output", got);
                end else begin
                    expv = exp_q.pop_front();
                    check("twiddle_seq", 32'(got), 32'(expv));
                    if (expv[0]) done_due = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic start_stage(input int n, input int s, input bit p, input bit iv, input bit poke);
        int lat;
        push_model(n, s, p, iv);
        base_hs = hs_cnt;
        @(negedge clk);
        n_log2 = NW'(n); stage = SW'(s); precision = p; inverse = iv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, 3);
        if (poke) begin
            n_log2 = NW'($urandom_range(1, L)); stage = '0;
            precision = ~p; inverse = ~iv; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic finish_stage(input int n);
        int t;
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("handshakes", hs_cnt - base_hs, 1 << (n - 1));
        @(negedge clk);
        check("done_one_cycle", 32'({done, busy}), 32'd0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic bad_cfg(input int n, input int s);
        int noise;
        @(negedge clk);
        n_log2 = NW'(n); stage = SW'(s); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", 32'({cfg_err, busy}), 32'h2);
        noise = 0;
        repeat (5) begin
            @(negedge clk);
            noise += int'(cfg_err) + int'(busy) + int'(out_valid);
        end
        check("cfg_err_quiet", noise, 0);
    endtask

    task automatic wait_hs(input int cnt);
        int t;
        t = 0;
        while (hs_cnt < base_hs + cnt && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reached_handshakes", 32'(hs_cnt >= base_hs + cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, base_stall;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({out_valid, twiddle_out, out_index, out_last, busy, done, cfg_err}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // N = 32, final stage, FP8, always ready
        ready_mode = 0;
        start_stage(5, 4, 1'b1, 1'b0, 1'b0);
        finish_stage(5);
        check("n32_k0", 32'(cap_tw[0]), 32'h3800);
        check("n32_k8", 32'(cap_tw[8]), 32'h00B8);

        // N = 8, s = 2, k = 1 in each format
        start_stage(3, 2, 1'b1, 1'b0, 1'b0);
        finish_stage(3);
        check("n8_k1_fp8", 32'(cap_tw[1]), 32'h33B3);
        start_stage(3, 2, 1'b0, 1'b0, 1'b0);
        finish_stage(3);
        check("n8_k1_fp4", 32'(cap_tw[1]), 32'h0019);
        start_stage(3, 2, 1'b1, 1'b1, 1'b0);
        finish_stage(3);
        check("n8_k1_fp8_inv", 32'(cap_tw[1]), 32'h3333);

        // N = 16, s = 1: k alternates 0, 4
        start_stage(4, 1, 1'b1, 1'b0, 1'b0);
        finish_stage(4);

        // five-cycle stall mid-stream
        ready_mode = 2;
        start_stage(5, 3, 1'b1, 1'b1, 1'b0);
        wait_hs(4);
        base_stall = stall_seen;
        stall_cnt  = 5;
        finish_stage(5);
        check("stall_cycles", stall_seen - base_stall, 5);
        ready_mode = 0;

        // rejected configurations
        bad_cfg(3, 3);
        bad_cfg(0, 0);
        bad_cfg(6, 1);
        bad_cfg(2, 5);

        // one-cycle reset during RUN, with a coincident start
        start_stage(5, 4, 1'b1, 1'b0, 1'b0);
        wait_hs(5);
        @(posedge clk); #1;
        mon_off = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        n_log2 = NW'(4); stage = SW'(2); start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", 32'({out_valid, twiddle_out, out_index, out_last, busy, done, cfg_err}), 32'd0);
        check("midrun_reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        check("reset_start_ignored", 32'({busy, out_valid}), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        mon_off = 1'b0;
        ready_mode = 1;
        start_stage(5, 4, 1'b1, 1'b0, 1'b0);
        finish_stage(5);

        // randomized stages with random back-pressure and ignored mid-run starts
        repeat (14) begin
            n = $urandom_range(1, L);
            s = $urandom_range(0, n - 1);
            start_stage(n, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            finish_stage(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
